set_assoc_cache_ctrl: RTL and testbench

Parametrised 2-way set-associative, write-through, no-write-allocate data cache controller between the ARM MEM stage and the line-wide SRAM controller. It generalises line size, set count and tag width. Write hits now update the cached word in place instead of invalidating the line. Line fill and write-through run on an explicit state machine with a registered SRAM handshake, and a flush command walks the array to invalidate it.

---
 rtl/set_assoc_cache_ctrl_pkg.sv | 32 +++
 rtl/cache_way_array.sv | 76 +++++++
 rtl/set_assoc_cache_ctrl.sv | 162 ++++++++++++++++
 tb/tb_set_assoc_cache_ctrl.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/set_assoc_cache_ctrl_pkg.sv
// Shared types for the 2-way write-through data cache: controller states,
// geometry helpers and the way-entry view returned by the storage array.
package cache_pkg;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FILL,
      ST_WRITE,
      ST_WDONE,
      ST_FLUSH
   } state_t;

   // Entry view is sized for the widest supported geometry (32-bit tag, 16-word line);
   // narrower configurations are zero-extended into it.
   localparam int TAG_MAX_W  = 32;
   localparam int LINE_MAX_W = 512;

   typedef struct packed {
      logic                  valid;
      logic [TAG_MAX_W-1:0]  tag;
      logic [LINE_MAX_W-1:0] data;
   } way_entry_t;

   function automatic int off_width(input int line_words);
      return $clog2(line_words) + 2;
   endfunction

   function automatic int line_width(input int line_words);
      return 32 * line_words;
   endfunction

endpackage

// File: rtl/cache_way_array.sv
// Two-way tag/data storage with combinational read, one line-or-word write port,
// and per-set valid/LRU clear for flushing.
module cache_way_array
   import cache_pkg::*;
#(
   parameter int  INDEX_W    = 6,
   parameter int  TAG_W      = 9,
   parameter int  LINE_WORDS = 2,
   localparam int LINE_W     = line_width(LINE_WORDS),
   localparam int WSEL_W     = off_width(LINE_WORDS) - 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [INDEX_W-1:0] index,
   output way_entry_t         way0,
   output way_entry_t         way1,
   output logic               lru,
   input  logic               wr_en,
   input  logic               wr_way,
   input  logic               wr_full,
   input  logic [TAG_W-1:0]   wr_tag,
   input  logic [LINE_W-1:0]  wr_line,
   input  logic [WSEL_W-1:0]  wr_sel,
   input  logic [31:0]        wr_word,
   input  logic               lru_we,
   input  logic               lru_val,
   input  logic               clr_en,
   input  logic [INDEX_W-1:0] clr_index
);

   localparam int SETS = 1 << INDEX_W;

   logic [TAG_W-1:0]  tag_mem  [2][SETS];
   logic [LINE_W-1:0] data_mem [2][SETS];
   logic [SETS-1:0]   valid_q  [2];
   logic [SETS-1:0]   lru_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q[0] <= '0;
         valid_q[1] <= '0;
         lru_q      <= '0;
      end else begin
         if (wr_en && wr_full) valid_q[wr_way][index] <= 1'b1;
         if (lru_we) lru_q[index] <= lru_val;
         if (clr_en) begin
            valid_q[0][clr_index] <= 1'b0;
            valid_q[1][clr_index] <= 1'b0;
            lru_q[clr_index]      <= 1'b0;
         end
      end
   end

   // Tag and data carry no reset: an entry is meaningless until its valid bit is set.
   always_ff @(posedge clk) begin
      if (wr_en) begin
         if (wr_full) begin
            tag_mem[wr_way][index]  <= wr_tag;
            data_mem[wr_way][index] <= wr_line;
         end else begin
            data_mem[wr_way][index][{wr_sel, 5'b0} +: 32] <= wr_word;
         end
      end
   end

   always_comb begin
      way0.valid = valid_q[0][index];
      way0.tag   = TAG_MAX_W'(tag_mem[0][index]);
      way0.data  = LINE_MAX_W'(data_mem[0][index]);
      way1.valid = valid_q[1][index];
      way1.tag   = TAG_MAX_W'(tag_mem[1][index]);
      way1.data  = LINE_MAX_W'(data_mem[1][index]);
      lru        = lru_q[index];
   end

endmodule

// File: rtl/set_assoc_cache_ctrl.sv
// 2-way set-associative write-through, no-write-allocate data cache controller
// sitting between the MEM stage and a line-wide SRAM controller.
module set_assoc_cache_ctrl
   import cache_pkg::*;
#(
   parameter int  INDEX_W    = 6,
   parameter int  TAG_W      = 9,
   parameter int  LINE_WORDS = 2,
   localparam int OFF_W      = off_width(LINE_WORDS),
   localparam int LINE_W     = line_width(LINE_WORDS)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              MEM_R_EN,
   input  logic              MEM_W_EN,
   input  logic [31:0]       Address,
   input  logic [31:0]       wdata,
   input  logic              flush,
   output logic [31:0]       rdata,
   output logic              ready,
   output logic [31:0]       sram_address,
   output logic [31:0]       sram_wdata,
   output logic              sram_read,
   output logic              sram_write,
   input  logic [LINE_W-1:0] sram_rdata,
   input  logic              sram_ready
);

   localparam int WSEL_W = OFF_W - 2;
   localparam int TAG_LO = OFF_W + INDEX_W;

   state_t             state_q, state_d;
   logic [INDEX_W-1:0] cnt_q, cnt_d;

   logic [WSEL_W-1:0]  word_sel;
   logic [INDEX_W-1:0] index;
   logic [TAG_W-1:0]   tag;
   logic               unused_addr;

   way_entry_t way0, way1;
   logic       lru, hit0, hit1, hit;
   logic       wr_en, wr_way, wr_full, lru_we, lru_val, clr_en;

   assign word_sel    = Address[OFF_W-1:2];
   assign index       = Address[OFF_W+INDEX_W-1:OFF_W];
   assign tag         = Address[TAG_LO+TAG_W-1:TAG_LO];
   assign unused_addr = ^{Address[31:TAG_LO+TAG_W], Address[1:0]};

   assign hit0  = way0.valid && (way0.tag == TAG_MAX_W'(tag));
   assign hit1  = way1.valid && (way1.tag == TAG_MAX_W'(tag));
   assign hit   = hit0 | hit1;
   assign rdata = hit1 ? way1.data[{word_sel, 5'b0} +: 32] :
                  hit0 ? way0.data[{word_sel, 5'b0} +: 32] : 32'h0;

   assign sram_wdata = wdata;

   cache_way_array #(
      .INDEX_W    (INDEX_W),
      .TAG_W      (TAG_W),
      .LINE_WORDS (LINE_WORDS)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .index     (index),
      .way0      (way0),
      .way1      (way1),
      .lru       (lru),
      .wr_en     (wr_en),
      .wr_way    (wr_way),
      .wr_full   (wr_full),
      .wr_tag    (tag),
      .wr_line   (sram_rdata),
      .wr_sel    (word_sel),
      .wr_word   (wdata),
      .lru_we    (lru_we),
      .lru_val   (lru_val),
      .clr_en    (clr_en),
      .clr_index (cnt_q)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= ST_IDLE;
         cnt_q      <= '0;
         sram_read  <= 1'b0;
         sram_write <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         sram_read  <= (state_d == ST_FILL);
         sram_write <= (state_d == ST_WRITE);
      end
   end

   // On every array update the LRU bit names the way that was not touched.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      ready        = 1'b0;
      wr_en        = 1'b0;
      wr_way       = 1'b0;
      wr_full      = 1'b0;
      lru_we       = 1'b0;
      lru_val      = 1'b0;
      clr_en       = 1'b0;
      sram_address = Address;
      case (state_q)
         ST_IDLE: begin
            if (MEM_W_EN) begin
               state_d = ST_WRITE;
            end else if (MEM_R_EN) begin
               if (hit) begin
                  ready   = 1'b1;
                  lru_we  = 1'b1;
                  lru_val = ~hit1;
               end else begin
                  state_d = ST_FILL;
               end
            end else begin
               ready = 1'b1;
               if (flush) begin
                  state_d = ST_FLUSH;
                  cnt_d   = '0;
               end
            end
         end
         ST_FILL: begin
            sram_address = {Address[31:OFF_W], {OFF_W{1'b0}}};
            if (sram_ready) begin
               wr_en   = 1'b1;
               wr_full = 1'b1;
               wr_way  = lru;
               lru_we  = 1'b1;
               lru_val = ~lru;
               state_d = ST_IDLE;
            end
         end
         ST_WRITE: begin
            if (sram_ready) begin
               if (hit) begin
                  wr_en   = 1'b1;
                  wr_way  = hit1;
                  lru_we  = 1'b1;
                  lru_val = ~hit1;
               end
               state_d = ST_WDONE;
            end
         end
         ST_WDONE: begin
            ready   = 1'b1;
            state_d = ST_IDLE;
         end
         ST_FLUSH: begin
            clr_en = 1'b1;
            cnt_d  = cnt_q + 1'b1;
            if (cnt_q == '1) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase
   end

endmodule

// File: tb/tb_set_assoc_cache_ctrl.sv
// Directed bench for set_assoc_cache_ctrl: a transaction table for reads/writes
// plus hand-written flush and reset-during-fill sequences.
module tb_set_assoc_cache_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        MEM_R_EN, MEM_W_EN, flush;
   logic [31:0] Address, wdata;
   logic [31:0] rdata, sram_address, sram_wdata;
   logic        ready, sram_read, sram_write;
   logic [63:0] sram_rdata;
   logic        sram_ready;

   int n_cmp = 0;
   int n_bad = 0;

   always #5 clk = ~clk;

   set_assoc_cache_ctrl dut (
      .clk          (clk),
      .rst          (rst),
      .MEM_R_EN     (MEM_R_EN),
      .MEM_W_EN     (MEM_W_EN),
      .Address      (Address),
      .wdata        (wdata),
      .flush        (flush),
      .rdata        (rdata),
      .ready        (ready),
      .sram_address (sram_address),
      .sram_wdata   (sram_wdata),
      .sram_read    (sram_read),
      .sram_write   (sram_write),
      .sram_rdata   (sram_rdata),
      .sram_ready   (sram_ready)
   );

   typedef struct {
      bit          is_wr;
      logic [31:0] addr;
      logic [31:0] data;
      logic [63:0] line;
      int          lat;
      bit          miss;
      logic [31:0] exp;
   } vec_t;

   vec_t vt[16];

   function automatic vec_t mk(bit is_wr, logic [31:0] addr, logic [31:0] data,
                               logic [63:0] line, int lat, bit miss, logic [31:0] exp);
      vec_t v;
      v.is_wr = is_wr; v.addr = addr; v.data = data; v.line = line;
      v.lat = lat; v.miss = miss; v.exp = exp;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h", name, got, exp);
      end
   endtask

   // Read transaction; on a miss the bench plays the SRAM after lat extra FILL cycles.
   task automatic do_read(input string nm, input logic [31:0] addr, input logic [63:0] line,
                          input int lat, input bit miss, input logic [31:0] exp);
      @(posedge clk); #1;
      MEM_R_EN = 1'b1;
      Address  = addr;
      @(negedge clk);
      check({nm, " first_cycle_ready"}, {31'b0, ready}, {31'b0, !miss});
      if (!ready) begin
         @(negedge clk);
         check({nm, " sram_read"}, {31'b0, sram_read}, 32'd1);
         check({nm, " fill_address"}, sram_address, {addr[31:3], 3'b000});
         repeat (lat) @(negedge clk);
         sram_rdata = line;
         sram_ready = 1'b1;
         @(negedge clk);
         sram_ready = 1'b0;
         check({nm, " sram_read_drop"}, {31'b0, sram_read}, 32'd0);
         check({nm, " replay_ready"}, {31'b0, ready}, 32'd1);
      end
      check({nm, " rdata"}, rdata, exp);
      @(posedge clk); #1;
      MEM_R_EN = 1'b0;
   endtask

   task automatic do_write(input string nm, input logic [31:0] addr, input logic [31:0] data,
                           input int lat);
      @(posedge clk); #1;
      MEM_W_EN = 1'b1;
      Address  = addr;
      wdata    = data;
      @(negedge clk);
      check({nm, " first_cycle_ready"}, {31'b0, ready}, 32'd0);
      @(negedge clk);
      check({nm, " sram_write"}, {31'b0, sram_write}, 32'd1);
      check({nm, " write_address"}, sram_address, addr);
      check({nm, " sram_wdata"}, sram_wdata, data);
      repeat (lat) @(negedge clk);
      sram_ready = 1'b1;
      @(negedge clk);
      sram_ready = 1'b0;
      check({nm, " sram_write_drop"}, {31'b0, sram_write}, 32'd0);
      check({nm, " wdone_ready"}, {31'b0, ready}, 32'd1);
      @(posedge clk); #1;
      MEM_W_EN = 1'b0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      int lo_cnt;

      // set 0x20 collects tags 0 (0x100), 1 (0x300), 2 (0x500), 3 (0x700)
      vt[0]  = mk(0, 32'h100,   0, 64'h0000BBBB_0000AAAA, 2, 1, 32'h0000AAAA);
      vt[1]  = mk(0, 32'h104,   0, 64'h0,                 0, 0, 32'h0000BBBB);
      vt[2]  = mk(0, 32'h300,   0, 64'h33330001_33330000, 1, 1, 32'h33330000);
      vt[3]  = mk(0, 32'h100,   0, 64'h0,                 0, 0, 32'h0000AAAA);
      vt[4]  = mk(0, 32'h504,   0, 64'h55550001_55550000, 0, 1, 32'h55550001);
      vt[5]  = mk(0, 32'h100,   0, 64'h0,                 0, 0, 32'h0000AAAA);
      vt[6]  = mk(0, 32'h300,   0, 64'h33330001_33330000, 1, 1, 32'h33330000);
      vt[7]  = mk(1, 32'h104,   32'h12345678, 64'h0,      1, 0, 32'h0);
      vt[8]  = mk(0, 32'h104,   0, 64'h0,                 0, 0, 32'h12345678);
      vt[9]  = mk(0, 32'h100,   0, 64'h0,                 0, 0, 32'h0000AAAA);
      vt[10] = mk(1, 32'h700,   32'hDEADBEEF, 64'h0,      2, 0, 32'h0);
      vt[11] = mk(0, 32'h700,   0, 64'h77770001_77770000, 1, 1, 32'h77770000);
      vt[12] = mk(0, 32'h104,   0, 64'h0,                 0, 0, 32'h12345678);
      vt[13] = mk(0, 32'h000,   0, 64'h000000A1_000000A0, 0, 1, 32'h000000A0);
      vt[14] = mk(0, 32'h1FC,   0, 64'h000000F1_000000F0, 3, 1, 32'h000000F1);
      vt[15] = mk(0, 32'h40104, 0, 64'h0,                 0, 0, 32'h12345678);

      rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; flush = 1'b0;
      Address = 32'h0; wdata = 32'h0; sram_rdata = 64'h0; sram_ready = 1'b0;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      check("reset ready", {31'b0, ready}, 32'd1);
      check("reset sram_read", {31'b0, sram_read}, 32'd0);
      check("reset sram_write", {31'b0, sram_write}, 32'd0);

      for (int i = 0; i < 16; i++) begin
         if (vt[i].is_wr) do_write($sformatf("v%0d", i), vt[i].addr, vt[i].data, vt[i].lat);
         else do_read($sformatf("v%0d", i), vt[i].addr, vt[i].line, vt[i].lat, vt[i].miss, vt[i].exp);
      end

      // flush raised together with a read hit: the read is served first
      @(posedge clk); #1;
      MEM_R_EN = 1'b1; Address = 32'h104; flush = 1'b1;
      @(negedge clk);
      check("flush_with_read ready", {31'b0, ready}, 32'd1);
      check("flush_with_read rdata", rdata, 32'h12345678);
      @(posedge clk); #1;
      MEM_R_EN = 1'b0;
      @(posedge clk); #1;
      flush = 1'b0;
      lo_cnt = 0;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (ready) break;
         lo_cnt++;
      end
      check("flush ready_low_cycles", lo_cnt, 64);
      do_read("post_flush_set0",  32'h000, 64'h000000A1_000000A0, 0, 1, 32'h000000A0);
      do_read("post_flush_set63", 32'h1FC, 64'h000000F1_000000F0, 1, 1, 32'h000000F1);
      do_read("post_flush_104",   32'h104, 64'h0000BBBB_0000AAAA, 1, 1, 32'h0000BBBB);

      // reset while a fill is outstanding, then a stray sram_ready in IDLE
      @(posedge clk); #1;
      MEM_R_EN = 1'b1; Address = 32'h300;
      @(negedge clk);
      check("rst_fill miss", {31'b0, ready}, 32'd0);
      @(negedge clk);
      check("rst_fill sram_read", {31'b0, sram_read}, 32'd1);
      @(posedge clk); #1;
      rst = 1'b1; MEM_R_EN = 1'b0;
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      check("rst_fill sram_read_cleared", {31'b0, sram_read}, 32'd0);
      check("rst_fill idle_ready", {31'b0, ready}, 32'd1);
      sram_rdata = 64'h99990001_99990000;
      sram_ready = 1'b1;
      @(negedge clk);
      sram_ready = 1'b0;
      do_read("after_rst_300", 32'h300, 64'h33330001_33330000, 1, 1, 32'h33330000);
      do_read("after_rst_104", 32'h104, 64'h0000BBBB_0000AAAA, 0, 1, 32'h0000BBBB);
      do_read("after_rst_000", 32'h000, 64'h000000A1_000000A0, 2, 1, 32'h000000A0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
